// File: rtl/char_seq_ctrl.sv
// Drives one char matcher per input byte: reset it, wait for m_rdy or timeout, report.
// Accept-to-result latency is RST_CYCLES+2 minimum; in_ready is low while a character is in flight.
module char_seq_ctrl #(
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 64,
   parameter int IDXW       = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [7:0]      in_data,
   input  logic            in_last,
   output logic            in_ready,
   output logic            m_reset,
   output logic [7:0]      m_x,
   input  logic            m_rdy,
   input  logic            m_y,
   output logic            res_valid,
   output logic            res_match,
   output logic            res_timeout,
   output logic [IDXW-1:0] res_index,
   output logic [IDXW-1:0] match_count,
   output logic            done
);

   localparam int CW = $clog2(RST_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RESET_M  = 2'd1,
      WAIT_RDY = 2'd2,
      REPORT   = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   rst_cnt;
   logic [TW-1:0]   timer;
   logic            last_q;
   logic            clear_pending;
   logic            accept;
   logic            expired;

   assign accept  = in_valid & in_ready;
   assign expired = (timer == TMR_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = RESET_M;
            end
         end
         RESET_M: begin
            if (rst_cnt == '0) begin
               state_nxt = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (m_rdy || expired) begin
               state_nxt = REPORT;
            end
         end
         REPORT: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The matcher stays in reset for as long as the controller does.
   always_comb begin
      in_ready  = (state == IDLE) & ~reset;
      m_reset   = reset | (state == RESET_M);
      res_valid = (state == REPORT);
      done      = (state == REPORT) & last_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_x           <= '0;
         last_q        <= 1'b0;
         clear_pending <= 1'b0;
         rst_cnt       <= '0;
         timer         <= '0;
         res_match     <= 1'b0;
         res_timeout   <= 1'b0;
         res_index     <= '0;
         match_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  m_x     <= in_data;
                  last_q  <= in_last;
                  rst_cnt <= RST_LOAD;
                  if (clear_pending) begin
                     res_index     <= '0;
                     match_count   <= '0;
                     clear_pending <= 1'b0;
                  end
               end
            end
            RESET_M: begin
               if (rst_cnt == '0) begin
                  timer <= '0;
               end else begin
                  rst_cnt <= rst_cnt - CW'(1);
               end
            end
            WAIT_RDY: begin
               // A ready arriving on the expiry cycle takes priority over the timeout.
               if (m_rdy) begin
                  res_match   <= m_y;
                  res_timeout <= 1'b0;
                  if (m_y && (match_count != '1)) begin
                     match_count <= match_count + IDXW'(1);
                  end
               end else if (expired) begin
                  res_match   <= 1'b0;
                  res_timeout <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            REPORT: begin
               if (last_q) begin
                  clear_pending <= 1'b1;
               end else begin
                  res_index <= res_index + IDXW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_char_seq_ctrl.sv
// Scoreboard bench for char_seq_ctrl with a simple char matcher model.
module tb_char_seq_ctrl;

   localparam int RC = 2;
   localparam int TO = 8;
   localparam int IW = 2;

   typedef struct packed {
      logic          m;
      logic          t;
      logic [IW-1:0] idx;
      logic [IW-1:0] cnt;
      logic          d;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_last;
   logic          in_ready;
   logic          m_reset;
   logic [7:0]    m_x;
   logic          m_rdy;
   logic          m_y;
   logic          res_valid;
   logic          res_match;
   logic          res_timeout;
   logic [IW-1:0] res_index;
   logic [IW-1:0] match_count;
   logic          done;

   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];

   // Matcher model: ready rdy_delay cycles after m_reset falls, match only on 'a'.
   int   wcnt      = 0;
   logic rdy_en    = 1'b1;
   int   rdy_delay = 3;

   always #5 clk = ~clk;

   always @(posedge clk) wcnt <= m_reset ? 0 : wcnt + 1;
   assign m_rdy = rdy_en && !m_reset && (wcnt == rdy_delay);
   assign m_y   = (m_x == 8'h61);

   char_seq_ctrl #(.RST_CYCLES(RC), .TIMEOUT(TO), .IDXW(IW)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .m_reset     (m_reset),
      .m_x         (m_x),
      .m_rdy       (m_rdy),
      .m_y         (m_y),
      .res_valid   (res_valid),
      .res_match   (res_match),
      .res_timeout (res_timeout),
      .res_index   (res_index),
      .match_count (match_count),
      .done        (done)
   );

   function automatic exp_t mk(input logic m, input logic t, input int i, input int c, input logic d);
      exp_t e;
      e.m   = m;
      e.t   = t;
      e.idx = IW'(i);
      e.cnt = IW'(c);
      e.d   = d;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every result strobe is compared against the oldest expectation.
   always @(negedge clk) begin
      exp_t a;
      exp_t e;
      if (res_valid) begin
         a = {res_match, res_timeout, res_index, match_count, done};
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL spurious_result: got m=%0d t=%0d idx=%0d cnt=%0d done=%0d, none expected",
                     a.m, a.t, a.idx, a.cnt, a.d);
         end else begin
            e = q.pop_front();
            if (a !== e) begin
               failures++;
               $display("FAIL result: got m=%0d t=%0d idx=%0d cnt=%0d done=%0d expected m=%0d t=%0d idx=%0d cnt=%0d done=%0d",
                        a.m, a.t, a.idx, a.cnt, a.d, e.m, e.t, e.idx, e.cnt, e.d);
            end
         end
      end
   end

   // w: cycles waited for in_ready, r: m_reset high cycles, n: cycles from WAIT entry to result.
   task automatic send(input logic [7:0] d, input logic l,
                       output int w, output int r, output int n, output int busy);
      w = 0;
      r = 0;
      n = 0;
      busy = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         w++;
         @(negedge clk);
      end
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      while (m_reset && r < 50) begin
         if (in_ready) busy++;
         r++;
         @(negedge clk);
      end
      while (!res_valid && n < 200) begin
         if (in_ready) busy++;
         n++;
         @(negedge clk);
      end
      if (!res_valid) begin
         failures++;
         $display("FAIL result_wait: got no res_valid within %0d cycles, required one", n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int r;
      int n;
      int b;
      int busy_sum;
      int seen;

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_m_reset", m_reset, 1);
      check("rst_in_ready", in_ready, 0);
      reset = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1);
      check("idle_m_reset", m_reset, 0);
      check("idle_res_valid", res_valid, 0);
      check("idle_index", res_index, 0);
      check("idle_count", match_count, 0);
      check("idle_m_x", m_x, 0);
      check("idle_done", done, 0);

      // Single 'a', last of string.
      q.push_back(mk(1, 0, 0, 1, 1));
      send(8'h61, 1'b1, w, r, n, b);
      check("t1_mreset_len", r, 2);
      check("t1_latency", n, 4);
      check("t1_busy", b, 0);

      // "abca": index restarts after the previous string's last char.
      busy_sum = 0;
      q.push_back(mk(1, 0, 0, 1, 0));
      send(8'h61, 1'b0, w, r, n, b);
      busy_sum += b;
      q.push_back(mk(0, 0, 1, 1, 0));
      send(8'h62, 1'b0, w, r, n, b);
      busy_sum += b;
      q.push_back(mk(0, 0, 2, 1, 0));
      send(8'h63, 1'b0, w, r, n, b);
      busy_sum += b;
      q.push_back(mk(1, 0, 3, 2, 1));
      send(8'h61, 1'b1, w, r, n, b);
      busy_sum += b;
      check("t2_busy", busy_sum, 0);
      check("t2_final_count", match_count, 2);

      // String "b": index and count clear on accept.
      q.push_back(mk(0, 0, 0, 0, 1));
      send(8'h62, 1'b1, w, r, n, b);

      // Timeout with a non-zero count, then expiry-cycle ready.
      q.push_back(mk(1, 0, 0, 1, 0));
      send(8'h61, 1'b0, w, r, n, b);
      rdy_en = 1'b0;
      q.push_back(mk(0, 1, 1, 1, 0));
      send(8'h61, 1'b0, w, r, n, b);
      check("t3_timeout_lat", n, 8);
      rdy_en    = 1'b1;
      rdy_delay = 7;
      q.push_back(mk(1, 0, 2, 2, 1));
      send(8'h61, 1'b1, w, r, n, b);
      check("t3_next_accept_wait", w, 0);
      check("t4_expiry_lat", n, 8);

      // Five chars with a 2-bit index: wraps 3 -> 0.
      rdy_delay = 3;
      for (int i = 0; i < 5; i++) begin
         q.push_back(mk(0, 0, i % 4, 0, (i == 4)));
         send(8'h62, (i == 4), w, r, n, b);
      end

      // Reset while in WAIT_RDY aborts the character.
      q.push_back(mk(1, 0, 0, 1, 0));
      send(8'h61, 1'b0, w, r, n, b);
      rdy_en = 1'b0;
      @(negedge clk);
      in_data  = 8'h63;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      r = 0;
      while (m_reset && r < 50) begin
         r++;
         @(negedge clk);
      end
      @(negedge clk);
      check("t5_pre_index", res_index, 1);
      check("t5_pre_count", match_count, 1);
      reset = 1'b1;
      #1;
      check("t5_m_reset_in_reset", m_reset, 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t5_in_ready_after", in_ready, 1);
      check("t5_index_after", res_index, 0);
      check("t5_count_after", match_count, 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      check("t5_no_result", seen, 0);
      check("queue_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
